// File: rtl/aes_ctrl.sv
// Sequencer and two-way arbiter in front of a single AES-128 core: per-requester key storage,
// key reload on ownership change, tagged responses. Optional core-timeout abort: AES_CTRL_TIMEOUT_EN.
module aes_ctrl #(
    parameter int TIMEOUT = 4000,
    parameter int TO_W    = 12
) (
    input  logic         clock,
    input  logic         resetb,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [1:0]   req_op,
    input  logic [127:0] req0_data,
    input  logic [127:0] req1_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic         rsp_err,
    output logic [127:0] rsp_data,
    output logic [127:0] core_key,
    output logic         core_key_load,
    output logic [127:0] core_block,
    output logic         core_start,
    input  logic         core_done,
    input  logic [127:0] core_result
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_KEY_LOAD  = 3'd1,
        S_KEY_WAIT  = 3'd2,
        S_BLK_START = 3'd3,
        S_BLK_WAIT  = 3'd4,
        S_RESP      = 3'd5
    } state_t;

    state_t       state_r, state_nx_s;
    logic [127:0] key0_r, key1_r;
    logic [1:0]   kv_r;
    logic         owner_v_r, owner_r, last_grant_r;
    logic         rsp_valid_r, rsp_id_r, rsp_err_r;
    logic [127:0] rsp_data_r, core_key_r, core_block_r;
    logic         core_key_load_r, core_start_r;
    logic         grant_s, accept_s, resident_s, to_exp_s;
    logic [127:0] req_data_s;

    if (TIMEOUT >= (64'd1 << TO_W)) begin : g_to_w_check
        $error("aes_ctrl: TO_W too narrow for TIMEOUT");
    end

`ifdef AES_CTRL_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_r;

    // Wait-cycle counter: runs while parked in a wait state, cleared everywhere else.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if ((state_r == S_KEY_WAIT || state_r == S_BLK_WAIT) && state_nx_s == state_r) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= {TO_W{1'b0}};
        end
    end

    assign to_exp_s = (to_cnt_r == TO_W'(TIMEOUT));
`else
    assign to_exp_s = 1'b0;
`endif

    // Arbitration and next-state decode; a tie goes to the requester not served last.
    always_comb begin
        grant_s    = 1'b0;
        accept_s   = 1'b0;
        state_nx_s = state_r;
        if (state_r == S_IDLE) begin
            accept_s = |req_valid;
            if (req_valid == 2'b11) begin
                grant_s = ~last_grant_r;
            end else begin
                grant_s = req_valid[1];
            end
        end else begin
            accept_s = 1'b0;
        end
        resident_s = owner_v_r && (owner_r == grant_s);
        req_data_s = grant_s ? req1_data : req0_data;
        case (state_r)
            S_IDLE: begin
                if (!accept_s) begin
                    state_nx_s = S_IDLE;
                end else if (req_op[grant_s] || !kv_r[grant_s]) begin
                    state_nx_s = S_RESP;
                end else if (resident_s) begin
                    state_nx_s = S_BLK_START;
                end else begin
                    state_nx_s = S_KEY_LOAD;
                end
            end
            S_KEY_LOAD:  state_nx_s = S_KEY_WAIT;
            S_KEY_WAIT: begin
                if (core_done) begin
                    state_nx_s = S_BLK_START;
                end else if (to_exp_s) begin
                    state_nx_s = S_RESP;
                end else begin
                    state_nx_s = S_KEY_WAIT;
                end
            end
            S_BLK_START: state_nx_s = S_BLK_WAIT;
            S_BLK_WAIT: begin
                if (core_done || to_exp_s) begin
                    state_nx_s = S_RESP;
                end else begin
                    state_nx_s = S_BLK_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_RESP;
                end
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Key store, core ownership, core strobes and response registers.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            key0_r          <= 128'd0;
            key1_r          <= 128'd0;
            kv_r            <= 2'b00;
            owner_v_r       <= 1'b0;
            owner_r         <= 1'b0;
            last_grant_r    <= 1'b1;
            rsp_valid_r     <= 1'b0;
            rsp_id_r        <= 1'b0;
            rsp_err_r       <= 1'b0;
            rsp_data_r      <= 128'd0;
            core_key_r      <= 128'd0;
            core_block_r    <= 128'd0;
            core_key_load_r <= 1'b0;
            core_start_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        last_grant_r <= grant_s;
                        rsp_id_r     <= grant_s;
                        if (req_op[grant_s]) begin
                            if (grant_s) begin
                                key1_r <= req_data_s;
                            end else begin
                                key0_r <= req_data_s;
                            end
                            kv_r[grant_s] <= 1'b1;
                            if (resident_s) begin
                                owner_v_r <= 1'b0;
                            end
                            rsp_err_r   <= 1'b0;
                            rsp_data_r  <= 128'd0;
                            rsp_valid_r <= 1'b1;
                        end else if (!kv_r[grant_s]) begin
                            rsp_err_r   <= 1'b1;
                            rsp_data_r  <= 128'd0;
                            rsp_valid_r <= 1'b1;
                        end else begin
                            core_block_r <= req_data_s;
                            if (resident_s) begin
                                core_start_r <= 1'b1;
                            end else begin
                                core_key_r      <= grant_s ? key1_r : key0_r;
                                core_key_load_r <= 1'b1;
                            end
                        end
                    end
                end
                S_KEY_LOAD: core_key_load_r <= 1'b0;
                S_KEY_WAIT: begin
                    if (core_done) begin
                        owner_r      <= rsp_id_r;
                        owner_v_r    <= 1'b1;
                        core_start_r <= 1'b1;
                    end else if (to_exp_s) begin
                        owner_v_r   <= 1'b0;
                        rsp_err_r   <= 1'b1;
                        rsp_data_r  <= 128'd0;
                        rsp_valid_r <= 1'b1;
                    end
                end
                S_BLK_START: core_start_r <= 1'b0;
                S_BLK_WAIT: begin
                    if (core_done) begin
                        rsp_data_r  <= core_result;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                    end else if (to_exp_s) begin
                        owner_v_r   <= 1'b0;
                        rsp_err_r   <= 1'b1;
                        rsp_data_r  <= 128'd0;
                        rsp_valid_r <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_r     <= 1'b0;
                    core_start_r    <= 1'b0;
                    core_key_load_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready     = accept_s ? (grant_s ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_id        = rsp_id_r;
    assign rsp_err       = rsp_err_r;
    assign rsp_data      = rsp_data_r;
    assign core_key      = core_key_r;
    assign core_key_load = core_key_load_r;
    assign core_block    = core_block_r;
    assign core_start    = core_start_r;

endmodule
